// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types, defaults and width helper for the conv frame scheduler
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_GAP,
        S_DONE
    } sched_state_t;

    localparam int DEF_IMG_WIDTH  = 224;
    localparam int DEF_IMG_HEIGHT = 224;
    localparam int DEF_GAP_CYCLES = 2;

    // Index width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_frame_scheduler_if.sv
// rtl/conv_frame_scheduler_if.sv - pixel-memory read and array control bundle
interface conv_frame_scheduler_if #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8
);
    logic             load_weight;
    logic             rd_en;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic             input_valid;

    modport master (
        output load_weight,
        output rd_en,
        output rd_row,
        output rd_col,
        output input_valid
    );

    modport slave (
        input load_weight,
        input rd_en,
        input rd_row,
        input rd_col,
        input input_valid
    );
endinterface

// File: rtl/sched_valid_delay.sv
// rtl/sched_valid_delay.sv - fixed-depth shift register aligning input_valid with memory read data
module sched_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) sr <= 1'b0;
                else        sr <= din;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!rst_n) sr <= '0;
                else        sr <= {sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv_frame_scheduler.sv
// rtl/conv_frame_scheduler.sv - walks 3-row windows across a frame, issuing column reads to pixel memory
module conv_frame_scheduler
    import conv_sched_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic stall,
    output logic busy,
    output logic frame_done,
    conv_frame_scheduler_if.master mem
);
    localparam int ROW_W = idx_width(IMG_HEIGHT);
    localparam int COL_W = idx_width(IMG_WIDTH);
    localparam int GAP_W = idx_width(GAP_CYCLES);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 3);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    sched_state_t     state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [GAP_W-1:0] gap_cnt;
    logic             load_weight_q;
    logic             rd_en_q;
    logic [ROW_W-1:0] rd_row_q;
    logic [COL_W-1:0] rd_col_q;
    logic             input_valid_d;

    // rd_en_q high means (row, col) is being issued this cycle; stall gates the next issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            row           <= '0;
            col           <= '0;
            gap_cnt       <= '0;
            load_weight_q <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_row_q      <= '0;
            rd_col_q      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            load_weight_q <= 1'b0;
            frame_done    <= 1'b0;
            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                rd_en_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state         <= S_LOAD_W;
                            load_weight_q <= 1'b1;
                            busy          <= 1'b1;
                        end
                    end
                    S_LOAD_W: begin
                        state   <= S_STREAM;
                        row     <= '0;
                        col     <= '0;
                        rd_en_q <= !stall;
                        if (!stall) begin
                            rd_row_q <= '0;
                            rd_col_q <= '0;
                        end
                    end
                    S_STREAM: begin
                        if (rd_en_q) begin
                            if (col == COL_LAST) begin
                                col     <= '0;
                                rd_en_q <= 1'b0;
                                if (row < ROW_LAST) begin
                                    row     <= row + 1'b1;
                                    gap_cnt <= '0;
                                    state   <= S_GAP;
                                end else begin
                                    state      <= S_DONE;
                                    frame_done <= 1'b1;
                                end
                            end else begin
                                col     <= col + 1'b1;
                                rd_en_q <= !stall;
                                if (!stall) begin
                                    rd_row_q <= row;
                                    rd_col_q <= col + 1'b1;
                                end
                            end
                        end else begin
                            rd_en_q <= !stall;
                            if (!stall) begin
                                rd_row_q <= row;
                                rd_col_q <= col;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state   <= S_STREAM;
                            rd_en_q <= !stall;
                            if (!stall) begin
                                rd_row_q <= row;
                                rd_col_q <= col;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    sched_valid_delay #(
        .DEPTH(RD_LATENCY)
    ) u_valid_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rd_en_q),
        .dout (input_valid_d)
    );

    assign mem.load_weight = load_weight_q;
    assign mem.rd_en       = rd_en_q;
    assign mem.rd_row      = rd_row_q;
    assign mem.rd_col      = rd_col_q;
    assign mem.input_valid = input_valid_d;
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// tb/tb_conv_frame_scheduler.sv - scoreboard bench for conv_frame_scheduler (5x4 frame, gap 2, latency 3)
module tb_conv_frame_scheduler;
    localparam int W   = 5;
    localparam int H   = 4;
    localparam int GAP = 2;
    localparam int LAT = 3;

    typedef struct {
        int cyc;
        int row;
        int col;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, stall;
    logic busy, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    rd_exp_t exp_rd[$];
    int      exp_lw[$];
    int      exp_fd[$];
    int      exp_busy[$];

    conv_frame_scheduler_if #(.ROW_W(2), .COL_W(3)) mem_if ();

    conv_frame_scheduler #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .GAP_CYCLES(GAP),
        .RD_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .stall     (stall),
        .busy      (busy),
        .frame_done(frame_done),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic report(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue k of a frame sits at t0+2 + row*(W+GAP) + col, pushed later by any stall before it.
    task automatic push_frame(input int t0, input int stall_k, input int stall_len,
                              input int last_k, input int done_off, input int busy_len);
        rd_exp_t e;
        exp_lw.push_back(t0 + 1);
        for (int k = 0; k <= last_k; k++) begin
            e.row = k / W;
            e.col = k % W;
            e.cyc = t0 + 2 + e.row * (W + GAP) + e.col + ((k >= stall_k) ? stall_len : 0);
            exp_rd.push_back(e);
        end
        if (done_off >= 0) exp_fd.push_back(t0 + done_off);
        exp_busy.push_back(busy_len);
    endtask

    task automatic check_idle_outputs(input string tag);
        report({tag, "_load_weight"}, int'(mem_if.load_weight), 0);
        report({tag, "_rd_en"},       int'(mem_if.rd_en),       0);
        report({tag, "_rd_row"},      int'(mem_if.rd_row),      0);
        report({tag, "_rd_col"},      int'(mem_if.rd_col),      0);
        report({tag, "_input_valid"}, int'(mem_if.input_valid), 0);
        report({tag, "_busy"},        int'(busy),               0);
        report({tag, "_frame_done"},  int'(frame_done),         0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic [2:0] hist = '0;
    logic       rst_prev = 1'b0;
    int         last_row = 0;
    int         last_col = 0;
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            rd_exp_t e;
            if (!rst_prev) begin
                hist     = '0;
                last_row = 0;
                last_col = 0;
            end
            report("input_valid", int'(mem_if.input_valid), int'(hist[2]));
            hist = {hist[1:0], mem_if.rd_en};
            if (mem_if.rd_en === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    report("rd_unexpected", 1, 0);
                end else begin
                    e = exp_rd.pop_front();
                    report("rd_cycle", cyc, e.cyc);
                    report("rd_row", int'(mem_if.rd_row), e.row);
                    report("rd_col", int'(mem_if.rd_col), e.col);
                    last_row = e.row;
                    last_col = e.col;
                end
            end else begin
                report("rd_row_hold", int'(mem_if.rd_row), last_row);
                report("rd_col_hold", int'(mem_if.rd_col), last_col);
            end
            if (mem_if.load_weight === 1'b1) begin
                if (exp_lw.size() == 0) report("load_weight_unexpected", 1, 0);
                else                    report("load_weight_cycle", cyc, exp_lw.pop_front());
            end
            if (frame_done === 1'b1) begin
                if (exp_fd.size() == 0) report("frame_done_unexpected", 1, 0);
                else                    report("frame_done_cycle", cyc, exp_fd.pop_front());
            end
            if (busy === 1'b1) begin
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                if (exp_busy.size() == 0) report("busy_unexpected", busy_cnt, 0);
                else                      report("busy_length", busy_cnt, exp_busy.pop_front());
                busy_cnt = 0;
            end
            rst_prev = rst_n;
        end
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Nominal frame: done 14 cycles after start, busy 14 cycles.
        t0 = cyc;
        start = 1'b1;
        push_frame(t0, 99, 0, 9, 14, 14);
        tick(1);
        start = 1'b0;
        tick(20);

        // Stall for 3 cycles while (0,1) is issued: (0,2) and later slip by 3.
        t0 = cyc;
        start = 1'b1;
        push_frame(t0, 2, 3, 9, 17, 17);
        tick(1);
        start = 1'b0;
        tick(2);
        stall = 1'b1;
        tick(3);
        stall = 1'b0;
        tick(20);

        // Start with abort in IDLE still launches; abort (with stall) at (1,1) ends the frame.
        t0 = cyc;
        start = 1'b1;
        abort = 1'b1;
        push_frame(t0, 99, 0, 6, -1, 10);
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tick(9);
        abort = 1'b1;
        stall = 1'b1;
        tick(1);
        abort = 1'b0;
        stall = 1'b0;
        report("abort_busy", int'(busy), 0);
        report("abort_rd_en", int'(mem_if.rd_en), 0);
        tick(5);

        // Complete frame after the abort.
        t0 = cyc;
        start = 1'b1;
        push_frame(t0, 99, 0, 9, 14, 14);
        tick(1);
        start = 1'b0;
        tick(20);

        // One-cycle reset while (0,2) is issued, with start held through the reset.
        t0 = cyc;
        start = 1'b1;
        push_frame(t0, 99, 0, 2, -1, 4);
        tick(1);
        start = 1'b0;
        tick(3);
        rst_n = 1'b0;
        start = 1'b1;
        tick(1);
        rst_n = 1'b1;
        start = 1'b0;
        check_idle_outputs("midreset");
        tick(8);

        // Start held high: back-to-back frames, one IDLE cycle between them.
        t0 = cyc;
        start = 1'b1;
        push_frame(t0, 99, 0, 9, 14, 14);
        push_frame(t0 + 15, 99, 0, 9, 14, 14);
        tick(17);
        start = 1'b0;
        tick(25);

        tick(6);
        report("left_rd",   exp_rd.size(),   0);
        report("left_lw",   exp_lw.size(),   0);
        report("left_fd",   exp_fd.size(),   0);
        report("left_busy", exp_busy.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
